uart_rx_ext: RTL and testbench

//  Next-generation AXI4-Stream UART receiver: runtime-selectable parity (none/even/odd) and 1 or 2 stop bits.
//  3-sample majority vote per bit; break detection; separate frame/parity/overrun error pulses.

---
 rtl/uart_rx_ext_pkg.sv | 22 ++
 rtl/uart_rx_ext_if.sv | 16 +
 rtl/uart_rx_ext_sampler.sv | 69 ++++++
 rtl/uart_rx_ext.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ext_pkg.sv
// rtl/uart_rx_ext_pkg.sv - shared codes for the extended UART receiver
// Purpose: parity mode codes, stop-bit codes and receiver FSM state encoding.
// Ports: none (package).
package uart_rx_ext_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_ext_if.sv
// rtl/uart_rx_ext_if.sv - stream interface carrying received characters
// Purpose: tdata/tvalid/tready bundle between receiver and downstream sink.
// Ports: tdata  character, tvalid  character present, tready  sink accepts.
// Modports: master (receiver side), slave (sink side).
interface uart_rx_ext_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_rx_ext_sampler.sv
// rtl/uart_rx_ext_sampler.sv - rxd synchroniser, bit timer and 3-sample majority
// Purpose: synchronises rxd, times each bit (prescale*8 clk) and votes on three samples.
// Ports: clk, rst_n       clock, async active-low reset
//        rxd              raw serial input
//        start            load the bit timer (start bit just detected)
//        active           a character is being timed
//        prescale         bit time divisor in effect for this character
//        rxd_sync         synchronised rxd
//        bit_valid        one cycle at the end of each timed bit
//        bit_value        majority of the three samples for that bit
module uart_rx_ext_sampler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        start,
  input  logic        active,
  input  logic [15:0] prescale,
  output logic        rxd_sync,
  output logic        bit_valid,
  output logic        bit_value
);

  logic        sync_a;
  logic        sync_b;
  logic [18:0] cnt;
  logic [18:0] cnt_load;
  logic [18:0] at_5p;
  logic [18:0] at_4p;
  logic [18:0] at_3p;
  logic [2:0]  smp;

  assign cnt_load = {prescale, 3'b000} - 19'd1;
  assign at_4p    = {1'b0, prescale, 2'b00};
  assign at_5p    = at_4p + {3'b000, prescale};
  assign at_3p    = {2'b00, prescale, 1'b0} + {3'b000, prescale};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= rxd;
      sync_b <= sync_a;
    end
  end

  assign rxd_sync = sync_b;

  // Samples land at 5p/4p/3p counts, all strictly above zero for prescale>=1,
  // so the vote is complete before the bit-end cycle reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      smp <= '0;
    end else if (start) begin
      cnt <= cnt_load;
      smp <= '0;
    end else if (active) begin
      cnt <= (cnt == 19'd0) ? cnt_load : cnt - 19'd1;
      if (cnt == at_5p) smp[0] <= sync_b;
      if (cnt == at_4p) smp[1] <= sync_b;
      if (cnt == at_3p) smp[2] <= sync_b;
    end
  end

  assign bit_valid = active && (cnt == 19'd0);
  assign bit_value = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx_ext.sv
// rtl/uart_rx_ext.sv - stream UART receiver with parity, 1/2 stop bits and break detect
// Purpose: frames characters from rxd, checks parity/stop, reports errors, emits on m_axis.
// Ports: clk, rst_n        clock, async active-low reset
//        m_axis           received characters (tdata/tvalid/tready)
//        rxd              serial input, idle high
//        busy             start-bit detect until return to idle
//        overrun_error    pulse: character completed while output still full
//        frame_error      pulse: stop bit sampled low (not a break)
//        parity_error     pulse: parity mismatch, character dropped
//        break_detect     pulse: every sampled bit of the frame was low
//        prescale         bit time = prescale*8 clk, 0 disables reception
//        parity_mode      00 none, 01 even, 10 odd, 11 none
//        stop_bits        0 one stop bit, 1 two stop bits
module uart_rx_ext
  import uart_rx_ext_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_ext_if.master        m_axis,
  input  logic                 rxd,
  output logic                 busy,
  output logic                 overrun_error,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 break_detect,
  input  logic [15:0]          prescale,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits
);

  rx_state_t             state;
  rx_state_t             state_next;

  logic                  rxd_sync;
  logic                  bit_valid;
  logic                  bit_value;
  logic                  start_det;
  logic                  timing;
  logic [15:0]           prescale_q;
  logic [15:0]           prescale_sel;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  stop_two_q;
  logic                  stop_idx;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_acc;
  logic                  any_one;
  logic                  stop_ok;
  logic                  done;
  logic                  brk_now;
  logic                  stop_ok_now;
  logic                  par_bad;
  logic                  char_ok;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;

  assign timing       = (state == ST_START) || (state == ST_DATA) ||
                        (state == ST_PARITY) || (state == ST_STOP);
  // The timer must load from the live prescale on the detect cycle, before it is latched.
  assign prescale_sel = start_det ? prescale : prescale_q;

  uart_rx_ext_sampler u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .start     (start_det),
    .active    (timing),
    .prescale  (prescale_sel),
    .rxd_sync  (rxd_sync),
    .bit_valid (bit_valid),
    .bit_value (bit_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_det   = 1'b0;
    done        = 1'b0;
    brk_now     = !(any_one | bit_value);
    stop_ok_now = stop_ok & bit_value;
    par_bad     = par_en_q && (par_acc != par_odd_q);
    case (state)
      ST_IDLE: begin
        if (!rxd_sync && (prescale != 16'd0)) begin
          start_det  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_valid) state_next = bit_value ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_valid && (bit_cnt == 4'(DATA_WIDTH - 1)))
          state_next = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_valid) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_valid && (!stop_two_q || stop_idx)) begin
          done       = 1'b1;
          state_next = brk_now ? ST_WAIT_HIGH : ST_IDLE;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxd_sync) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy    = (state != ST_IDLE) || start_det;
  assign char_ok = done && !brk_now && stop_ok_now && !par_bad;

  // Per-character accumulation; configuration is frozen at start detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop_two_q <= 1'b0;
      stop_idx   <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      any_one    <= 1'b0;
      stop_ok    <= 1'b1;
    end else if (start_det) begin
      prescale_q <= prescale;
      par_en_q   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_odd_q  <= (parity_mode == PAR_ODD);
      stop_two_q <= (stop_bits == STOP_TWO);
      stop_idx   <= 1'b0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      any_one    <= 1'b0;
      stop_ok    <= 1'b1;
    end else if (bit_valid) begin
      case (state)
        ST_DATA: begin
          shreg   <= {bit_value, shreg[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
          par_acc <= par_acc ^ bit_value;
          any_one <= any_one | bit_value;
        end
        ST_PARITY: begin
          par_acc <= par_acc ^ bit_value;
          any_one <= any_one | bit_value;
        end
        ST_STOP: begin
          stop_ok  <= stop_ok & bit_value;
          any_one  <= any_one | bit_value;
          stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output register and error pulses; errors are mutually exclusive in priority order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      break_detect  <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      frame_error   <= done && !brk_now && !stop_ok_now;
      parity_error  <= done && !brk_now && stop_ok_now && par_bad;
      break_detect  <= done && brk_now;
      if (char_ok) begin
        tdata_q       <= shreg;
        tvalid_q      <= 1'b1;
        overrun_error <= tvalid_q && !m_axis.tready;
      end else if (tvalid_q && m_axis.tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb/tb_uart_rx_ext.sv - self-checking bench for uart_rx_ext
module tb_uart_rx_ext;
  import uart_rx_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        busy;
  logic        overrun_error;
  logic        frame_error;
  logic        parity_error;
  logic        break_detect;
  logic [15:0] prescale = 16'd1;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits = 1'b0;

  uart_rx_ext_if #(.DATA_WIDTH(8)) axis ();

  uart_rx_ext #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis        (axis),
    .rxd           (rxd),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .break_detect  (break_detect),
    .prescale      (prescale),
    .parity_mode   (parity_mode),
    .stop_bits     (stop_bits)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] rxq[$];
  int n_fe = 0, n_pe = 0, n_brk = 0, n_ovr = 0;

  always @(negedge clk) begin
    if (axis.tvalid && axis.tready) rxq.push_back(axis.tdata);
    if (frame_error)   n_fe++;
    if (parity_error)  n_pe++;
    if (break_detect)  n_brk++;
    if (overrun_error) n_ovr++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clr_mon();
    @(negedge clk);
    rxq.delete();
    n_fe = 0; n_pe = 0; n_brk = 0; n_ovr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int p);
    rxd = v;
    repeat (8 * p) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pb,
                            input logic two, input logic s1, input logic s2, input int p);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (has_par) drive_bit(pb, p);
    drive_bit(s1, p);
    if (two) drive_bit(s2, p);
    rxd = 1'b1;
  endtask

  // Reference: outcome of a frame from its line bits by the documented priority.
  // kind 0 = character, 1 = frame error, 2 = parity error, 3 = break.
  function automatic int model(input logic [7:0] d, input logic [1:0] pm, input logic two,
                               input logic pb, input logic s1, input logic s2);
    bit has_par, all_zero, stop_bad, par_bad;
    int ones;
    has_par  = (pm == 2'b01) || (pm == 2'b10);
    ones     = $countones(d) + ((has_par && pb) ? 1 : 0);
    all_zero = (ones == 0) && !s1 && !(two && s2);
    stop_bad = !s1 || (two && !s2);
    par_bad  = has_par && ((ones % 2) != ((pm == 2'b10) ? 1 : 0));
    if (all_zero) return 3;
    if (stop_bad) return 1;
    if (par_bad)  return 2;
    return 0;
  endfunction

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       two;
    logic       pb;
    logic       s1;
    logic       s2;
    int         n;
    logic [7:0] xd;
    int         fe;
    int         pe;
    int         brk;
  } vec_t;

  vec_t vec[12];

  task automatic check_frame(input string tag, input int en, input logic [7:0] exd,
                             input int efe, input int epe, input int ebrk);
    chk({tag, " nchar"}, rxq.size(), en);
    if (rxq.size() > 0 && en > 0) chk({tag, " data"}, int'(rxq[0]), int'(exd));
    chk({tag, " frame_err"}, n_fe, efe);
    chk({tag, " parity_err"}, n_pe, epe);
    chk({tag, " break"}, n_brk, ebrk);
    chk({tag, " overrun"}, n_ovr, 0);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  initial begin
    int kind, p, seen;
    logic [7:0] d;
    logic [1:0] pm;
    logic two, pb, s1, s2;

    vec[0]  = '{8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'h55, 0, 0, 0};
    vec[1]  = '{8'hA3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'hA3, 0, 0, 0};
    vec[2]  = '{8'hA3, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 8'h00, 0, 1, 0};
    vec[3]  = '{8'hA3, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1, 8'hA3, 0, 0, 0};
    vec[4]  = '{8'h3C, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1, 0, 0};
    vec[5]  = '{8'h3C, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1, 0, 0};
    vec[6]  = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 0, 0, 1};
    vec[7]  = '{8'h00, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1, 0, 0};
    vec[8]  = '{8'hFF, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h00, 0, 1, 0};
    vec[9]  = '{8'h81, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'h81, 0, 0, 0};
    vec[10] = '{8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h00, 0, 0, 0};
    vec[11] = '{8'h5A, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h5A, 0, 0, 0};

    axis.tready = 1'b1;
    idle(3);
    chk("reset tdata", int'(axis.tdata), 0);
    chk("reset tvalid", int'(axis.tvalid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset pulses", int'({overrun_error, frame_error, parity_error, break_detect}), 0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 12; i++) begin
      parity_mode = vec[i].pm;
      stop_bits   = vec[i].two;
      prescale    = 16'd1;
      clr_mon();
      send_frame(vec[i].d, (vec[i].pm == 2'd1) || (vec[i].pm == 2'd2), vec[i].pb,
                 vec[i].two, vec[i].s1, vec[i].s2, 1);
      idle(40);
      check_frame($sformatf("vec%0d", i), vec[i].n, vec[i].xd, vec[i].fe, vec[i].pe, vec[i].brk);
    end

    // Overrun: two back-to-back characters while the sink stalls.
    parity_mode = 2'd0; stop_bits = 1'b0; axis.tready = 1'b0;
    clr_mon();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    idle(40);
    chk("ovr pulses", n_ovr, 1);
    chk("ovr tvalid held", int'(axis.tvalid), 1);
    chk("ovr tdata", int'(axis.tdata), 8'h22);
    chk("ovr no transfer", rxq.size(), 0);
    axis.tready = 1'b1;
    idle(3);
    chk("ovr drained", rxq.size(), 1);
    if (rxq.size() > 0) chk("ovr drained data", int'(rxq[0]), 8'h22);
    chk("ovr tvalid cleared", int'(axis.tvalid), 0);

    // Break: line low for 20 bit times.
    clr_mon();
    rxd = 1'b0;
    idle(160);
    chk("brk busy while low", int'(busy), 1);
    chk("brk pulses", n_brk, 1);
    chk("brk no frame_err", n_fe, 0);
    chk("brk no char", rxq.size(), 0);
    rxd = 1'b1;
    idle(10);
    chk("brk busy after high", int'(busy), 0);

    // One-cycle glitch on an idle line at prescale=4: false start.
    prescale = 16'd4;
    clr_mon();
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("glitch start seen", seen, 1);
    idle(100);
    check_frame("glitch", 0, 8'h00, 0, 0, 0);

    // Receiver disabled with prescale=0.
    prescale = 16'd0;
    clr_mon();
    rxd = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    rxd = 1'b1;
    idle(5);
    chk("disabled busy", seen, 0);

    // One-cycle flip inside each data bit of 0x96: majority restores it.
    prescale = 16'd1;
    clr_mon();
    drive_bit(1'b0, 1);
    d = 8'h96;
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];  idle(4);
      rxd = ~d[i]; idle(1);
      rxd = d[i];  idle(3);
    end
    drive_bit(1'b1, 1);
    idle(40);
    check_frame("flip96", 1, 8'h96, 0, 0, 0);

    // Reset in the middle of DATA.
    clr_mon();
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 1);
    drive_bit(1'b1, 1);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    chk("midrst tdata", int'(axis.tdata), 0);
    chk("midrst tvalid", int'(axis.tvalid), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst pulses", int'({overrun_error, frame_error, parity_error, break_detect}), 0);
    rxd = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(40);
    check_frame("after rst", 0, 8'h00, 0, 0, 0);

    // Randomised frames against the reference model.
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      pm  = 2'($urandom);
      two = 1'($urandom);
      p   = $urandom_range(1, 3);
      pb  = (^d) ^ (pm == 2'b10) ^ ($urandom_range(0, 3) == 0);
      s1  = ($urandom_range(0, 5) != 0);
      s2  = ($urandom_range(0, 5) != 0);
      if (d == 8'h00 && $urandom_range(0, 1) == 0) begin s1 = 1'b0; s2 = 1'b0; pb = 1'b0; end
      kind = model(d, pm, two, pb, s1, s2);
      parity_mode = pm; stop_bits = two; prescale = 16'(p);
      clr_mon();
      send_frame(d, (pm == 2'b01) || (pm == 2'b10), pb, two, s1, s2, p);
      idle(40 * p);
      check_frame($sformatf("rnd%0d", i), (kind == 0) ? 1 : 0, d,
                  (kind == 1) ? 1 : 0, (kind == 2) ? 1 : 0, (kind == 3) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
